// File: rtl/uart_tx_scheduler_if.sv
// Purpose: request/data/ack bundle between byte producers and the UART TX scheduler.
// Latency: none, wires only.
// Backpressure: producers hold req[i] with stable data until the one-cycle ack[i].
// Ports: req (per-producer byte pending), data (byte i at [8*i+7:8*i]), ack (one-hot latch pulse).
interface uart_tx_scheduler_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] data;
   logic [NUM_REQ-1:0]   ack;

   // master = byte producers, slave = scheduler
   modport master (output req, output data, input ack);
   modport slave  (input req, input data, output ack);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Purpose: round-robin shares one 8N1 UART TX line between NUM_REQ byte producers.
// Latency: ack and start bit one cycle after a request is seen in IDLE; frame = 10*DIV cycles.
// Backpressure: producers hold req until ack; requests are only sampled while the line is idle.
// Ports: clk; rst_n (synchronous, active low); bus (slave: req/data in, ack out);
//        tx_o serial line (idle high); busy_o high while a frame is on the line.
module uart_tx_scheduler #(
   parameter int CLOCK_RATE = 27500000,
   parameter int BAUD_RATE  = 15625,
   parameter int NUM_REQ    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_scheduler_if.slave bus,
   output logic               tx_o,
   output logic               busy_o
);
   localparam int DIV = CLOCK_RATE / BAUD_RATE;
   localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW  = $clog2(NUM_REQ);
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t             state_q, state_d;
   logic [BW-1:0]      baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [PW-1:0]      ptr_q, ptr_d;   // index where the next search starts

   logic               tick;
   logic               grant_vld;
   logic [PW-1:0]      grant_idx;
   int                 arb_idx;
   int                 win_idx;

   // Bit-end strobe: last cycle of the current bit period
   assign tick = (baud_q == BAUD_LAST);

   // Round-robin pick: first pending requester at or after ptr_q, wrapping
   always_comb begin
      grant_vld = 1'b0;
      win_idx   = 0;
      arb_idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb_idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!grant_vld && bus.req[arb_idx]) begin
            grant_vld = 1'b1;
            win_idx   = arb_idx;
         end
      end
      grant_idx = PW'(win_idx);
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      ack_d   = '0;
      ptr_d   = ptr_q;

      // The baud counter only runs while a frame is on the line
      if (state_q != S_IDLE) begin
         baud_d = tick ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            baud_d = '0;
            if (grant_vld) begin
               ack_d[grant_idx] = 1'b1;
               shift_d          = bus.data[8*win_idx +: 8];
               tx_d             = 1'b0;
               busy_d           = 1'b1;
               state_d          = S_START;
               ptr_d            = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  // shift_q[0] is on the line now; its successor is shift_q[1]
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ack_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         ptr_q   <= ptr_d;
      end
   end

   assign tx_o    = tx_q;
   assign busy_o  = busy_q;
   assign bus.ack = ack_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: bench for uart_tx_scheduler at DIV=16 with two requesters.
// Latency: outputs compared every cycle on the falling edge against a frame-level model.
// Backpressure: stimulus drops each req on its ack like a real producer.
module tb_uart_tx_scheduler;
   localparam int CLOCK_RATE = 160;
   localparam int BAUD_RATE  = 10;
   localparam int NUM_REQ    = 2;
   localparam int DIV        = CLOCK_RATE / BAUD_RATE;
   localparam int FRAME      = 10 * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tx_o;
   logic busy_o;

   uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_scheduler #(
      .CLOCK_RATE(CLOCK_RATE),
      .BAUD_RATE (BAUD_RATE),
      .NUM_REQ   (NUM_REQ)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .tx_o  (tx_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int errors  = 0;
   int checks  = 0;
   int cyc     = 0;
   bit started = 1'b0;

   // Frame-level model: position inside the current frame, -1 when the line is idle
   int                 m_pos  = -1;
   int                 m_rr   = 0;
   int                 m_w    = 0;
   logic [7:0]         m_byte = 8'h00;
   logic               m_tx   = 1'b1;
   logic               m_busy = 1'b0;
   logic [NUM_REQ-1:0] m_ack  = '0;

   function automatic logic frame_bit(input int pos, input logic [7:0] b);
      int k;
      k = pos / DIV;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] obs();
      return 32'({bus.ack, busy_o, tx_o});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      started = 1'b1;
      m_ack   = '0;
      if (!rst_n) begin
         m_pos = -1;
         m_rr  = 0;
      end else if (m_pos >= 0) begin
         m_pos++;
         if (m_pos == FRAME) m_pos = -1;
      end else if (bus.req != '0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            m_w = (m_rr + k) % NUM_REQ;
            if (m_pos < 0 && bus.req[m_w]) begin
               m_pos      = 0;
               m_byte     = bus.data[8*m_w +: 8];
               m_ack[m_w] = 1'b1;
               m_rr       = (m_w + 1) % NUM_REQ;
            end
         end
      end
      m_tx   = (m_pos < 0) ? 1'b1 : frame_bit(m_pos, m_byte);
      m_busy = (m_pos >= 0);
   end

   always @(negedge clk) begin
      if (started) check("cycle", obs(), 32'({m_ack, m_busy, m_tx}));
   end

   task automatic wait_ack(input int budget, output int who, output int when);
      bit got;
      got  = 1'b0;
      who  = -1;
      when = -1;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (bus.ack != '0) begin
            got  = 1'b1;
            when = cyc;
            who  = (bus.ack == 2'b10) ? 1 : ((bus.ack == 2'b01) ? 0 : -1);
         end
      end
      check("ack_seen", 32'(got), 32'h1);
   endtask

   task automatic wait_idle(input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (!busy_o) got = 1'b1;
      end
      check("idle_seen", 32'(got), 32'h1);
   endtask

   logic wave [0:FRAME-1];
   int   a5_bits [0:7] = '{1, 0, 1, 0, 0, 1, 0, 1};
   int   rr_w [0:3]    = '{-1, -1, -1, -1};
   int   rr_t [0:3]    = '{0, 0, 0, 0};

   initial begin
      int w, t, bad, busyc, ackc, lows, ng;
      logic [NUM_REQ-1:0] rearm;

      bus.req  = '0;
      bus.data = '0;
      rst_n    = 1'b0;

      // Reset, then a long idle stretch
      repeat (3) @(negedge clk);
      check("reset_state", obs(), 32'h1);
      rst_n = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (obs() != 32'h1) bad++;
      end
      check("idle_200", bad, 0);

      // Single byte 0xA5 from requester 0; data changes after the grant must not matter
      bus.data[7:0] = 8'hA5;
      bus.req       = 2'b01;
      wait_ack(8, w, t);
      check("single_ack", 32'(bus.ack), 32'h1);
      bus.req       = '0;
      bus.data[7:0] = 8'h00;
      busyc = 0;
      ackc  = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge clk);
         wave[i] = tx_o;
         busyc  += int'(busy_o);
         if (bus.ack != '0) ackc++;
      end
      lows = 0;
      for (int i = 0; i < DIV; i++) if (!wave[i]) lows++;
      check("single_start_low", lows, DIV);
      check("single_bit0_edge", 32'(wave[DIV]), 32'h1);
      for (int k = 0; k < 8; k++)
         check($sformatf("single_bit%0d", k), 32'(wave[DIV*(k+1) + DIV/2]), a5_bits[k]);
      check("single_stop_first", 32'(wave[9*DIV]), 32'h1);
      check("single_stop_last", 32'(wave[FRAME-1]), 32'h1);
      check("single_busy_len", busyc, FRAME);
      check("single_ack_count", ackc, 1);
      @(negedge clk);
      check("single_end_idle", obs(), 32'h1);

      // Round robin with both requesters held, fresh pointer
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n    = 1'b1;
      bus.data = {8'h0F, 8'h55};
      bus.req  = 2'b11;
      ng       = 0;
      rearm    = '0;
      for (int i = 0; i < 1000 && ng < 4; i++) begin
         @(negedge clk);
         if (rearm != '0) begin
            bus.req = bus.req | rearm;
            rearm   = '0;
         end
         if (bus.ack != '0) begin
            rr_w[ng] = (bus.ack == 2'b10) ? 1 : 0;
            rr_t[ng] = cyc;
            ng++;
            rearm    = bus.ack;
            bus.req  = bus.req & ~bus.ack;
         end
      end
      bus.req = '0;
      check("rr_grants", ng, 4);
      check("rr_w0", rr_w[0], 0);
      check("rr_w1", rr_w[1], 1);
      check("rr_w2", rr_w[2], 0);
      check("rr_w3", rr_w[3], 1);
      for (int k = 0; k < 3; k++)
         check($sformatf("rr_gap%0d", k), rr_t[k+1] - rr_t[k], FRAME + 1);
      wait_idle(400);

      // Late request from requester 1 during requester 0's frame
      bus.data[7:0] = 8'h3C;
      bus.req       = 2'b01;
      wait_ack(8, w, t);
      check("late_first_w", w, 0);
      bus.req = '0;
      repeat (50) @(negedge clk);
      bus.data[15:8] = 8'hC3;
      bus.req        = 2'b10;
      wait_idle(400);
      check("late_gap_noack", 32'(bus.ack), 32'h0);
      @(negedge clk);
      check("late_ack", 32'(bus.ack), 32'h2);
      bus.req = '0;

      // One-cycle request while busy: never granted
      repeat (30) @(negedge clk);
      bus.req = 2'b01;
      @(negedge clk);
      bus.req = '0;
      wait_idle(400);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (bus.ack != '0 || !tx_o || busy_o) bad++;
      end
      check("withdrawn_idle", bad, 0);

      // Reset in the middle of data bit 3
      bus.data[7:0] = 8'hF0;
      bus.req       = 2'b01;
      wait_ack(8, w, t);
      bus.req = '0;
      repeat (4*DIV + 6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_state", obs(), 32'h1);
      @(negedge clk);
      bus.data[15:8] = 8'h81;
      bus.req        = 2'b10;
      rst_n          = 1'b1;
      @(negedge clk);
      check("midrst_ack", 32'(bus.ack), 32'h2);
      bus.req = '0;
      wait_idle(400);

      // After requester 0 wins, a reset must hand priority back to requester 0
      bus.data[7:0] = 8'h5A;
      bus.req       = 2'b01;
      wait_ack(8, w, t);
      bus.req = '0;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      bus.data = {8'h11, 8'h22};
      bus.req  = 2'b11;
      rst_n    = 1'b1;
      @(negedge clk);
      check("rst_ptr_ack", 32'(bus.ack), 32'h1);
      bus.req = '0;
      wait_idle(400);
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
